hour12_set_to24: RTL and testbench
==================================

Name: hour12_set_to24

Overview:
- Hour-setting front end for the digital clock.
- Lets the user edit the hour in 12-hour form (BCD 1..12 plus an AM/PM flag) using push-button pulses.
- On confirm, converts the edited value to a 24-hour BCD hour and issues a one-cycle load pulse to the hour counter.
- Sits between the debounced key pulses and the 24-hour hour counter; it is the inverse path of the 24-to-12 display conversion.

Parameters:
RESET_HOUR24, 8'h00, 24-hour BCD value driven on hour24_out after reset (legal BCD 00..23 only).

Ports:
clk  in  1  system clock
cr  in  1  synchronous active-high clear
set_en  in  1  level; high = set mode requested
inc  in  1  one-cycle pulse; advance edited hour by 1
ampm_tgl  in  1  one-cycle pulse; toggle edited AM/PM
confirm  in  1  one-cycle pulse; commit edited value
hour24_in  in  8  current 24-hour BCD hour from the hour counter
hour12  out  8  edited hour, BCD 01..12 (display)
pm  out  1  edited AM/PM flag, 1 = PM
editing  out  1  high while in EDIT
hour24_out  out  8  committed 24-hour BCD hour, 00..23
load  out  1  one-cycle pulse; hour24_out is valid to load

Behaviour:
- Clock, reset and width rules:
  - Single clock. cr is synchronous and active-high; it has priority over all other inputs.
  - Reset values: state=IDLE, hour12=8'h12, pm=0, editing=0, hour24_out=RESET_HOUR24, load=0.
- States:
  - IDLE: editing=0. On set_en=1, go to CAPTURE.
  - CAPTURE (1 cycle): register the 24-to-12 conversion of hour24_in into hour12/pm, then go to EDIT.
    - 00 -> 12 AM.
    - 01..11 -> same value, AM.
    - 12 -> 12 PM.
    - 13..23 -> 01..11 PM.
    - 24 or any non-BCD / out-of-range code -> 12 AM.
  - EDIT: editing=1.
    - inc: hour12 goes 01->02->...->11->12->01 in BCD (09->10 and 12->01 wrap); pm is unchanged by the wrap.
    - ampm_tgl: pm inverts.
    - inc and ampm_tgl in the same cycle: both apply.
    - confirm: go to COMMIT. confirm takes priority; inc and ampm_tgl in the confirm cycle are ignored.
    - set_en=0 without confirm: abort to IDLE; no load, hour24_out unchanged.
  - COMMIT (1 cycle): hour24_out <= 12-to-24 conversion of hour12/pm; load=1 for exactly this cycle; then go to IDLE.
    - 12 AM -> 00.
    - 01..11 AM -> same.
    - 12 PM -> 12.
    - 01..11 PM -> BCD +12, i.e. 13..23, with correct decimal carry (08 PM -> 20, 09 PM -> 21, 11 PM -> 23).
- Latency and outputs:
  - confirm sampled in cycle N -> load=1 and the new hour24_out visible in cycle N+1.
  - hour24_out holds its value until the next COMMIT or cr.
- Re-entry: if set_en is still high after COMMIT, the block passes through IDLE for one cycle and then recaptures. The hour counter has loaded the new value by then, so it is captured back.
- Idle hold: inc, ampm_tgl and confirm outside EDIT are ignored; hour12/pm hold their last value.
- cr mid-edit: immediate return to IDLE with reset values; no load is issued.
- hour12 is always legal BCD 01..12 and hour24_out is always legal BCD 00..23.

Decomposition:
- Shared package (clock_pkg): state encoding (IDLE, CAPTURE, EDIT, COMMIT) and BCD constants (H12_MIN=8'h01, H12_MAX=8'h12, H24_NOON=8'h12, H24_MAX=8'h23).
- One combinational sub-module, bcd_h12_to_h24, holds the 12-to-24 mapping. It is reused by any alarm-set path.
- The 24-to-12 capture mapping is local to this block.

Test Plan:
- cr held 2 cycles -> hour24_out=8'h00, hour12=8'h12, pm=0, load=0, editing=0.
- hour24_in=8'h17, set_en=1, confirm with no edits -> after CAPTURE hour12=8'h05, pm=1; load pulse one cycle after confirm with hour24_out=8'h17.
- hour24_in=8'h00, set_en=1, 10 inc pulses, 1 ampm_tgl, confirm -> hour12 steps 12,01,...,10; pm=1; hour24_out=8'h22, load high exactly 1 cycle.
- hour24_in=8'h11, set_en=1, inc then ampm_tgl, confirm -> hour12 becomes 12 with pm=0; after the toggle, 12 PM; commit gives hour24_out=8'h12. Repeat with a second toggle -> 12 AM -> hour24_out=8'h00.
- In EDIT, inc and confirm in the same cycle -> inc ignored, committed hour equals the pre-cycle value. Separately: set_en dropped before confirm -> no load, hour24_out unchanged.
- cr asserted during EDIT after 3 inc pulses -> next cycle IDLE, hour12=8'h12, no load. Separately: hour24_in=8'h24 captured -> hour12=8'h12, pm=0.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared hour-set state encoding, BCD constants and helpers
//
// Purpose: state encoding for the hour-set FSM, BCD hour limits, and small
// BCD helpers shared by the 24/12-hour conversion paths.
// Ports: none (package).
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EDIT    = 2'd2,
    ST_COMMIT  = 2'd3
  } set_state_e;

  localparam logic [7:0] H12_MIN  = 8'h01;
  localparam logic [7:0] H12_MAX  = 8'h12;
  localparam logic [7:0] H24_NOON = 8'h12;
  localparam logic [7:0] H24_MAX  = 8'h23;

  // Binary 0..19 to two-digit BCD; used for the small hour values only.
  function automatic logic [7:0] bin_to_bcd2(input logic [4:0] v);
    logic [7:0] r;
    if (v >= 5'd10) begin
      r = {4'h1, 4'(v - 5'd10)};
    end else begin
      r = {4'h0, v[3:0]};
    end
    return r;
  endfunction

  // 12-hour BCD increment: 01..11 step up with decimal carry, 12 wraps to 01.
  // Anything at or above 12 (including illegal codes) lands on 01.
  function automatic logic [7:0] bcd_inc12(input logic [7:0] h);
    logic [7:0] r;
    if (h >= H12_MAX) begin
      r = H12_MIN;
    end else if (h[3:0] >= 4'd9) begin
      r = {h[7:4] + 4'd1, 4'h0};
    end else begin
      r = {h[7:4], h[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_h12_to_h24.sv
// rtl/bcd_h12_to_h24.sv - combinational 12-hour BCD + AM/PM to 24-hour BCD
//
// Purpose: maps a 12-hour BCD hour (01..12) and PM flag to a 24-hour BCD
// hour (00..23). Shared by the hour-set and alarm-set paths.
// Ports:
//   hour12_i  in  8  12-hour BCD hour, 01..12
//   pm_i      in  1  1 = PM
//   hour24_o  out 8  24-hour BCD hour, 00..23
module bcd_h12_to_h24
  import clock_pkg::*;
(
  input  logic [7:0] hour12_i,
  input  logic       pm_i,
  output logic [7:0] hour24_o
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic [4:0] ones_p2;
  logic       legal;

  always_comb begin
    tens     = hour12_i[7:4];
    ones     = hour12_i[3:0];
    ones_p2  = {1'b0, ones} + 5'd2;
    legal    = ((tens == 4'd0) && (ones >= 4'd1) && (ones <= 4'd9)) ||
               ((tens == 4'd1) && (ones <= 4'd2));
    hour24_o = 8'h00;

    if (!legal) begin
      // Keep the output inside 00..23 even if fed garbage.
      hour24_o = 8'h00;
    end else if (hour12_i == H12_MAX) begin
      hour24_o = pm_i ? H24_NOON : 8'h00;
    end else if (!pm_i) begin
      hour24_o = hour12_i;
    end else if (ones_p2 > 5'd9) begin
      // +12 with a carry out of the ones digit: 08 PM -> 20, 09 PM -> 21.
      hour24_o = {tens + 4'd2, 4'(ones_p2 - 5'd10)};
    end else begin
      hour24_o = {tens + 4'd1, ones_p2[3:0]};
    end
  end

endmodule

// File: rtl/hour12_set_to24.sv
// rtl/hour12_set_to24.sv - 12-hour hour-set editor committing a 24-hour load
//
// Purpose: captures the running 24-hour hour as 12-hour BCD + AM/PM, lets the
// user step the hour and toggle AM/PM, and on confirm issues a one-cycle load
// of the 24-hour equivalent to the hour counter.
// Ports:
//   clk        in  1  system clock
//   cr         in  1  synchronous active-high clear, highest priority
//   set_en     in  1  level, set mode requested
//   inc        in  1  pulse, advance edited hour
//   ampm_tgl   in  1  pulse, toggle edited AM/PM
//   confirm    in  1  pulse, commit edited value
//   hour24_in  in  8  current 24-hour BCD hour
//   hour12     out 8  edited hour, BCD 01..12
//   pm         out 1  edited AM/PM flag, 1 = PM
//   editing    out 1  high while in EDIT
//   hour24_out out 8  committed 24-hour BCD hour
//   load       out 1  one-cycle load strobe for hour24_out
module hour12_set_to24
  import clock_pkg::*;
#(
  parameter logic [7:0] RESET_HOUR24 = 8'h00
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       set_en,
  input  logic       inc,
  input  logic       ampm_tgl,
  input  logic       confirm,
  input  logic [7:0] hour24_in,
  output logic [7:0] hour12,
  output logic       pm,
  output logic       editing,
  output logic [7:0] hour24_out,
  output logic       load
);

  set_state_e state_q, state_d;
  logic [7:0] hour12_q, hour12_d;
  logic       pm_q, pm_d;
  logic [7:0] hour24_q, hour24_d;
  logic       load_q, load_d;

  logic [7:0] cap_h12;
  logic       cap_pm;
  logic [7:0] commit_h24;

  // 24-to-12 capture mapping.
  logic [3:0] in_tens;
  logic [3:0] in_ones;
  logic [4:0] in_bin;
  logic       in_legal;

  always_comb begin
    in_tens  = hour24_in[7:4];
    in_ones  = hour24_in[3:0];
    in_legal = (in_ones <= 4'd9) &&
               ((in_tens <= 4'd1) || ((in_tens == 4'd2) && (in_ones <= 4'd3)));
    in_bin   = (5'(in_tens) * 5'd10) + 5'(in_ones);
    cap_h12  = H12_MAX;
    cap_pm   = 1'b0;

    if (!in_legal || (in_bin == 5'd0)) begin
      // Midnight and every unusable code both show as 12 AM.
      cap_h12 = H12_MAX;
      cap_pm  = 1'b0;
    end else if (in_bin < 5'd12) begin
      cap_h12 = bin_to_bcd2(in_bin);
      cap_pm  = 1'b0;
    end else if (in_bin == 5'd12) begin
      cap_h12 = H12_MAX;
      cap_pm  = 1'b1;
    end else begin
      cap_h12 = bin_to_bcd2(in_bin - 5'd12);
      cap_pm  = 1'b1;
    end
  end

  bcd_h12_to_h24 u_h12_to_h24 (
    .hour12_i (hour12_q),
    .pm_i     (pm_q),
    .hour24_o (commit_h24)
  );

  always_comb begin
    state_d  = state_q;
    hour12_d = hour12_q;
    pm_d     = pm_q;
    hour24_d = hour24_q;
    load_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (set_en) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        hour12_d = cap_h12;
        pm_d     = cap_pm;
        state_d  = ST_EDIT;
      end
      ST_EDIT: begin
        if (confirm) begin
          // The committed value is registered on the edge into COMMIT so
          // that load and the new hour24_out appear together one cycle
          // after confirm. Edits in this cycle are dropped.
          state_d  = ST_COMMIT;
          hour24_d = commit_h24;
          load_d   = 1'b1;
        end else if (!set_en) begin
          state_d = ST_IDLE;
        end else begin
          if (inc) begin
            hour12_d = bcd_inc12(hour12_q);
          end
          if (ampm_tgl) begin
            pm_d = ~pm_q;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      state_q  <= ST_IDLE;
      hour12_q <= H12_MAX;
      pm_q     <= 1'b0;
      hour24_q <= RESET_HOUR24;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour12_q <= hour12_d;
      pm_q     <= pm_d;
      hour24_q <= hour24_d;
      load_q   <= load_d;
    end
  end

  assign hour12     = hour12_q;
  assign pm         = pm_q;
  assign editing    = (state_q == ST_EDIT);
  assign hour24_out = hour24_q;
  assign load       = load_q;

endmodule

// File: tb/tb_hour12_set_to24.sv
// tb/tb_hour12_set_to24.sv - directed self-checking bench for hour12_set_to24
module tb_hour12_set_to24;

  logic       clk = 1'b0;
  logic       cr = 1'b1;
  logic       set_en = 1'b0;
  logic       inc = 1'b0;
  logic       ampm_tgl = 1'b0;
  logic       confirm = 1'b0;
  logic [7:0] hour24_in = 8'h00;
  logic [7:0] hour12;
  logic       pm;
  logic       editing;
  logic [7:0] hour24_out;
  logic       load;

  int checks = 0;
  int failures = 0;

  logic [7:0] inc_seq [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                               8'h06, 8'h07, 8'h08, 8'h09, 8'h10};

  always #5 clk = ~clk;

  hour12_set_to24 #(.RESET_HOUR24(8'h00)) dut (
    .clk        (clk),
    .cr         (cr),
    .set_en     (set_en),
    .inc        (inc),
    .ampm_tgl   (ampm_tgl),
    .confirm    (confirm),
    .hour24_in  (hour24_in),
    .hour12     (hour12),
    .pm         (pm),
    .editing    (editing),
    .hour24_out (hour24_out),
    .load       (load)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // From IDLE with set_en already high: IDLE -> CAPTURE -> EDIT.
  task automatic enter_edit(input logic [7:0] h24);
    hour24_in = h24;
    set_en = 1'b1;
    step();
    step();
  endtask

  initial begin
    // Reset held two cycles.
    cr = 1'b1;
    step();
    step();
    chk8("rst_h24", hour24_out, 8'h00);
    chk8("rst_h12", hour12, 8'h12);
    chk1("rst_pm", pm, 1'b0);
    chk1("rst_load", load, 1'b0);
    chk1("rst_edit", editing, 1'b0);
    cr = 1'b0;
    step();

    // 17 -> 05 PM, commit unchanged.
    enter_edit(8'h17);
    chk1("t2_edit", editing, 1'b1);
    chk8("t2_h12", hour12, 8'h05);
    chk1("t2_pm", pm, 1'b1);
    chk1("t2_noload", load, 1'b0);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    set_en = 1'b0;
    chk1("t2_load", load, 1'b1);
    chk8("t2_h24", hour24_out, 8'h17);
    chk1("t2_edit_off", editing, 1'b0);
    step();
    chk1("t2_load_end", load, 1'b0);
    chk8("t2_h24_hold", hour24_out, 8'h17);

    // 00 -> 12 AM, ten increments through the 09->10 carry, toggle, 10 PM = 22.
    enter_edit(8'h00);
    chk8("t3_h12_cap", hour12, 8'h12);
    chk1("t3_pm_cap", pm, 1'b0);
    for (int i = 0; i < 10; i++) begin
      inc = 1'b1;
      step();
      chk8($sformatf("t3_inc%0d", i), hour12, inc_seq[i]);
    end
    inc = 1'b0;
    chk1("t3_pm_after_inc", pm, 1'b0);
    ampm_tgl = 1'b1;
    step();
    ampm_tgl = 1'b0;
    chk1("t3_pm_tgl", pm, 1'b1);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    set_en = 1'b0;
    chk1("t3_load", load, 1'b1);
    chk8("t3_h24", hour24_out, 8'h22);
    step();
    chk1("t3_load_once", load, 1'b0);

    // 11 AM -> inc -> 12 AM (pm unchanged) -> toggle -> 12 PM -> 12.
    enter_edit(8'h11);
    chk8("t4_h12_cap", hour12, 8'h11);
    inc = 1'b1;
    step();
    inc = 1'b0;
    chk8("t4_h12_inc", hour12, 8'h12);
    chk1("t4_pm_inc", pm, 1'b0);
    ampm_tgl = 1'b1;
    step();
    ampm_tgl = 1'b0;
    chk1("t4_pm_tgl", pm, 1'b1);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    chk1("t4_load", load, 1'b1);
    chk8("t4_h24", hour24_out, 8'h12);
    // set_en still high: one IDLE cycle then recapture of the loaded hour.
    hour24_in = 8'h12;
    step();
    chk1("t4_idle_edit", editing, 1'b0);
    chk1("t4_idle_load", load, 1'b0);
    step();
    step();
    chk1("t4_re_edit", editing, 1'b1);
    chk8("t4_re_h12", hour12, 8'h12);
    chk1("t4_re_pm", pm, 1'b1);
    ampm_tgl = 1'b1;
    step();
    ampm_tgl = 1'b0;
    chk1("t4_pm_tgl2", pm, 1'b0);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    set_en = 1'b0;
    chk1("t4_load2", load, 1'b1);
    chk8("t4_h24_mid", hour24_out, 8'h00);
    step();

    // inc together with confirm: inc dropped, 09 AM commits as 09.
    enter_edit(8'h09);
    inc = 1'b1;
    confirm = 1'b1;
    step();
    inc = 1'b0;
    confirm = 1'b0;
    set_en = 1'b0;
    chk1("t5_load", load, 1'b1);
    chk8("t5_h24", hour24_out, 8'h09);
    chk8("t5_h12", hour12, 8'h09);
    step();

    // Abort: set_en drops in EDIT, no load, hour24_out untouched.
    enter_edit(8'h20);
    chk8("t5_h12_20", hour12, 8'h08);
    chk1("t5_pm_20", pm, 1'b1);
    inc = 1'b1;
    step();
    inc = 1'b0;
    chk8("t5_h12_inc", hour12, 8'h09);
    set_en = 1'b0;
    step();
    chk1("t5_abort_edit", editing, 1'b0);
    chk1("t5_abort_load", load, 1'b0);
    step();
    chk1("t5_abort_load2", load, 1'b0);
    chk8("t5_abort_h24", hour24_out, 8'h09);

    // cr mid-edit after three increments.
    enter_edit(8'h05);
    for (int i = 0; i < 3; i++) begin
      inc = 1'b1;
      step();
    end
    inc = 1'b0;
    chk8("t6_h12_pre", hour12, 8'h08);
    cr = 1'b1;
    step();
    cr = 1'b0;
    set_en = 1'b0;
    chk1("t6_edit", editing, 1'b0);
    chk8("t6_h12", hour12, 8'h12);
    chk1("t6_pm", pm, 1'b0);
    chk1("t6_load", load, 1'b0);
    chk8("t6_h24", hour24_out, 8'h00);
    step();
    chk1("t6_load2", load, 1'b0);

    // Out-of-range capture codes fall back to 12 AM.
    enter_edit(8'h23);
    chk8("t7_h12_23", hour12, 8'h11);
    chk1("t7_pm_23", pm, 1'b1);
    set_en = 1'b0;
    step();
    enter_edit(8'h24);
    chk8("t7_h12_24", hour12, 8'h12);
    chk1("t7_pm_24", pm, 1'b0);
    set_en = 1'b0;
    step();
    enter_edit(8'h1A);
    chk8("t7_h12_1a", hour12, 8'h12);
    chk1("t7_pm_1a", pm, 1'b0);

    // Idle hold: pulses outside EDIT are ignored.
    set_en = 1'b0;
    step();
    inc = 1'b1;
    ampm_tgl = 1'b1;
    confirm = 1'b1;
    step();
    inc = 1'b0;
    ampm_tgl = 1'b0;
    confirm = 1'b0;
    step();
    chk8("t8_h12_hold", hour12, 8'h12);
    chk1("t8_pm_hold", pm, 1'b0);
    chk1("t8_load", load, 1'b0);
    chk8("t8_h24", hour24_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
